// File: rtl/turtle_mem_pkg.sv
// Shared definitions for the data RAM and the blocks that drive it.
// Holds RAM geometry, mover state encoding and mode constants.
package turtle_mem_pkg;

   localparam int RAM_ADDR_W = 10;
   localparam int RAM_DATA_W = 16;

   localparam logic MODE_FILL = 1'b0;
   localparam logic MODE_COPY = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/ram_block_mover.sv
// Block fill / block copy initiator for the single-port data RAM.
// Owns the RAM port while busy; COPY alternates RD and WR cycles.
module ram_block_mover
   import turtle_mem_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

   state_e            r_state;
   logic              r_mode;
   logic [ADDR_W-1:0] r_src_ptr;
   logic [ADDR_W-1:0] r_dst_ptr;
   logic [ADDR_W:0]   r_remaining;
   logic [DATA_W-1:0] r_fill;
   logic              r_busy;
   logic              r_done;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;

   logic              w_copy_wr;
   logic              w_last;
   logic [ADDR_W-1:0] w_src_nxt;
   logic [ADDR_W-1:0] w_dst_nxt;

   assign w_copy_wr = (r_state == WR) && (r_mode == MODE_COPY);
   assign w_last    = (r_remaining == LEN_ONE);
   assign w_src_nxt = r_src_ptr + 1'b1;
   assign w_dst_nxt = r_dst_ptr + 1'b1;

   // COPY writes forward the word read back in the preceding RD cycle
   assign ram_din   = w_copy_wr ? ram_dout : r_din;
   assign busy      = r_busy;
   assign done      = r_done;
   assign ram_write = r_write;
   assign ram_addr  = r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mode      <= MODE_FILL;
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_fill      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_din       <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done  <= 1'b0;
               r_write <= 1'b0;
               if (start) begin
                  r_mode      <= mode;
                  r_src_ptr   <= src_addr;
                  r_dst_ptr   <= dst_addr;
                  r_remaining <= length;
                  r_fill      <= fill_value;
                  if (length == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else if (mode == MODE_COPY) begin
                     r_state <= RD;
                     r_busy  <= 1'b1;
                     r_addr  <= src_addr;
                  end else begin
                     r_state <= WR;
                     r_busy  <= 1'b1;
                     r_write <= 1'b1;
                     r_addr  <= dst_addr;
                     r_din   <= fill_value;
                  end
               end
            end
            RD: begin
               r_state <= WR;
               r_write <= 1'b1;
               r_addr  <= r_dst_ptr;
            end
            WR: begin
               r_src_ptr   <= w_src_nxt;
               r_dst_ptr   <= w_dst_nxt;
               r_remaining <= r_remaining - 1'b1;
               if (w_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_write <= 1'b0;
               end else if (r_mode == MODE_COPY) begin
                  r_state <= RD;
                  r_write <= 1'b0;
                  r_addr  <= w_src_nxt;
               end else begin
                  r_state <= WR;
                  r_write <= 1'b1;
                  r_addr  <= w_dst_nxt;
                  r_din   <= r_fill;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_write <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover with a behavioural data RAM attached.
// Memory contents are predicted by a word-by-word array model.
module tb_ram_block_mover;
   import turtle_mem_pkg::*;

   localparam int AW = RAM_ADDR_W;
   localparam int DW = RAM_DATA_W;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] fill_value = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_write;
   logic [DW-1:0] ram_dout;

   logic [DW-1:0] mem     [N];
   logic [DW-1:0] ref_mem [N];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ram_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_write  (ram_write),
      .ram_dout   (ram_dout)
   );

   // data RAM: clears on reset, one-cycle read, dout held on writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
         ram_dout <= '0;
      end else if (ram_write) begin
         mem[ram_addr] <= ram_din;
      end else begin
         ram_dout <= mem[ram_addr];
      end
   end

   function automatic void chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endfunction

   function automatic int exp_latency(input logic m, input int len);
      if (len == 0) return 1;
      return m ? 2 * len + 1 : len + 1;
   endfunction

   // ascending word-at-a-time semantics, so overlap is modelled naturally
   task automatic model_op(input logic m, input logic [AW-1:0] s,
                           input logic [AW-1:0] d, input int len,
                           input logic [DW-1:0] v);
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      for (int i = 0; i < len; i++) begin
         a = d + AW'(i);
         b = s + AW'(i);
         ref_mem[a] = m ? ref_mem[b] : v;
      end
   endtask

   task automatic check_mem(input string nm);
      int mism;
      mism = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] !== ref_mem[i]) mism++;
      chk({nm, " mem_mismatch"}, mism, 0);
   endtask

   task automatic run_op(input string nm, input logic m,
                         input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int len, input logic [DW-1:0] v,
                         input int inj_k, input logic [AW-1:0] inj_d,
                         input int exp_lat);
      int k, lat, wr_n, wr_bad, busy_bad, done_n, ecyc;
      logic [AW-1:0] ea;
      lat = -1; wr_n = 0; wr_bad = 0; busy_bad = 0; done_n = 0;
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d;
      length = (AW+1)'(len); fill_value = v;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (k <= exp_lat + 8) begin
         if (ram_write) begin
            ea = d + AW'(wr_n);
            ecyc = m ? 2 * (wr_n + 1) : wr_n + 1;
            if (ram_addr !== ea || k != ecyc) wr_bad++;
            wr_n++;
         end
         if (busy !== (k < exp_lat)) busy_bad++;
         if (done === 1'b1) begin
            if (done_n == 0) lat = k;
            done_n++;
         end
         if (k == inj_k) begin
            start = 1'b1; dst_addr = inj_d; src_addr = inj_d;
         end else begin
            start = 1'b0;
         end
         if (done_n > 0 && k >= lat + 3) break;
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      model_op(m, s, d, len, v);
      chk({nm, " done_latency"}, lat, exp_lat);
      chk({nm, " write_count"}, wr_n, len);
      chk({nm, " write_addr_cycle_errs"}, wr_bad, 0);
      chk({nm, " busy_errs"}, busy_bad, 0);
      chk({nm, " done_pulses"}, done_n, 1);
      check_mem(nm);
   endtask

   typedef struct {
      string         nm;
      logic          m;
      logic [AW-1:0] s;
      logic [AW-1:0] d;
      int            len;
      logic [DW-1:0] v;
      int            inj_k;
      logic [AW-1:0] inj_d;
      int            lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int k, done_n, len;
      logic m;
      for (int i = 0; i < N; i++) ref_mem[i] = '0;

      #12;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset write", int'(ram_write), 0);
      chk("reset addr", int'(ram_addr), 0);
      chk("reset din", int'(ram_din), 0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{"pre0", MODE_FILL, 10'h000, 10'h000, 1, 16'h1111, 0, 10'h0, 2});
      vecs.push_back('{"pre1", MODE_FILL, 10'h000, 10'h001, 1, 16'h2222, 0, 10'h0, 2});
      vecs.push_back('{"pre2", MODE_FILL, 10'h000, 10'h002, 1, 16'h3333, 0, 10'h0, 2});
      vecs.push_back('{"fill4", MODE_FILL, 10'h000, 10'h010, 4, 16'hBEEF, 0, 10'h0, 5});
      vecs.push_back('{"copy3", MODE_COPY, 10'h000, 10'h100, 3, 16'h0000, 0, 10'h0, 7});
      vecs.push_back('{"fill_len0", MODE_FILL, 10'h000, 10'h200, 0, 16'hFFFF, 0, 10'h0, 1});
      vecs.push_back('{"copy_len0", MODE_COPY, 10'h000, 10'h200, 0, 16'h0000, 0, 10'h0, 1});
      vecs.push_back('{"fill_wrap", MODE_FILL, 10'h000, 10'h3FE, 4, 16'hA5A5, 0, 10'h0, 5});
      vecs.push_back('{"copy_busy_start", MODE_COPY, 10'h010, 10'h300, 8, 16'h0000, 3, 10'h080, 17});
      vecs.push_back('{"fill_done_start", MODE_FILL, 10'h000, 10'h040, 2, 16'h5A5A, 3, 10'h050, 3});
      vecs.push_back('{"copy_overlap", MODE_COPY, 10'h010, 10'h012, 4, 16'h0000, 0, 10'h0, 9});
      vecs.push_back('{"copy_wrap", MODE_COPY, 10'h3FF, 10'h1FE, 3, 16'h0000, 0, 10'h0, 7});
      vecs.push_back('{"fill_all", MODE_FILL, 10'h000, 10'h155, 1024, 16'hC3C3, 0, 10'h0, 1025});

      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].len,
                vecs[i].v, vecs[i].inj_k, vecs[i].inj_d, vecs[i].lat);

      for (int r = 0; r < 15; r++) begin
         m   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
         run_op("rand", m, AW'($urandom), AW'($urandom), len,
                DW'($urandom), 0, '0, exp_latency(m, len));
      end

      // reset in the middle of a FILL
      @(negedge clk);
      start = 1'b1; mode = MODE_FILL; dst_addr = 10'h200;
      length = 11'd10; fill_value = 16'h1234;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midreset busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midreset busy", int'(busy), 0);
      chk("midreset done", int'(done), 0);
      chk("midreset write", int'(ram_write), 0);
      chk("midreset addr", int'(ram_addr), 0);
      chk("midreset din", int'(ram_din), 0);
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
      done_n = 0;
      for (k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done === 1'b1) done_n++;
      end
      rst_n = 1'b1;
      for (k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done === 1'b1 || ram_write === 1'b1) done_n++;
      end
      chk("midreset no_activity", done_n, 0);
      check_mem("midreset");
      run_op("after_reset", MODE_FILL, 10'h000, 10'h201, 1, 16'h7777, 0, '0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_block_mover.md
Name: ram_block_mover

Overview:
- Bus initiator that drives the single-port data RAM interface (addr/din/write in, dout out) to perform block fill and block copy without CPU involvement.
- Sits between the MCU control/peripheral logic and the data RAM and owns the RAM port while busy.
- The RAM it drives has the following properties:
  - a read presented in cycle N has valid dout after the clock edge ending cycle N;
  - dout holds its value during write cycles;
  - the RAM clears to zero on reset.

Parameters:
- ADDR_W, 10, RAM address width (word addressed).
- DATA_W, 16, RAM data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = FILL, 1 = COPY; sampled with start.
- src_addr  in  ADDR_W  COPY source base; sampled with start.
- dst_addr  in  ADDR_W  destination base; sampled with start.
- length  in  ADDR_W+1  word count, 0..1024; sampled with start.
- fill_value  in  DATA_W  FILL data; sampled with start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at completion.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_write  out  1  to RAM write.
- ram_dout  in  DATA_W  from RAM dout.

Behaviour:
- Reset (async, any state): state = IDLE; busy = 0, done = 0, ram_write = 0, ram_addr = 0, ram_din = 0; all internal counters and latched operands cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RD, WR, DONE. All outputs are registered or decoded from registered state; ram_din in COPY WR is ram_dout passed through.
- IDLE:
  - start = 1 latches mode, src, dst, len, fill_value.
  - len == 0 → DONE.
  - FILL → WR.
  - COPY → RD.
  - start while not IDLE is ignored; nothing is queued.
- RD (COPY only): ram_addr = src_ptr, ram_write = 0. Next state is always WR.
- WR:
  - ram_addr = dst_ptr, ram_write = 1.
  - ram_din = fill_value (FILL) or ram_dout (COPY; the word read in the preceding RD cycle).
  - Then src_ptr++, dst_ptr++, remaining--.
  - remaining reaching 0 → DONE.
  - Otherwise COPY → RD, FILL → WR.
- DONE: done = 1 for exactly one cycle, busy = 0, ram_write = 0; next state IDLE. A start asserted in DONE is ignored.
- Throughput: FILL = 1 cycle/word, COPY = 2 cycles/word. Completion latency from the start cycle:
  - FILL: len + 1 cycles to the done pulse.
  - COPY: 2·len + 1 cycles to the done pulse.
  - len = 0: done pulses in the cycle after start.
- Pointer arithmetic is modulo 2^ADDR_W: 0x3FF + 1 wraps to 0x000. len = 1024 is legal and touches every address once.
- Overlap: copy is always ascending. When dst > src and the ranges overlap, the source is overwritten before it is read; this is the defined result, not an error.
- Outside WR, ram_write = 0 and ram_addr/ram_din hold their last values. Only the ram_write = 0 guarantee is checked.
- busy = 1 in RD and WR only.

Decomposition:
- Shared package turtle_mem_pkg:
  - state enum (IDLE, RD, WR, DONE);
  - mode constants MODE_FILL = 0, MODE_COPY = 1;
  - RAM_ADDR_W = 10, RAM_DATA_W = 16 (used as parameter defaults here and by the RAM).
- Single flat module. No sub-module: the pointer/counter logic is too small to justify one.
- The bench instantiates the existing RAM alongside this block.

Test Plan:
- FILL, dst 0x010, len 4, fill_value 0xBEEF → ram_write high for 4 consecutive cycles with addr 0x010..0x013; done pulses 5 cycles after start; words 0x00F and 0x014 remain 0x0000.
- Preload 0x000..0x002 = 0x1111/0x2222/0x3333; COPY src 0x000, dst 0x100, len 3 → alternating RD/WR; 0x100..0x102 match the source; done pulses 7 cycles after start.
- len 0, both modes → no write cycle; done pulses in the cycle after start; busy never rises.
- FILL, dst 0x3FE, len 4, value 0xA5A5 → writes to 0x3FE, 0x3FF, 0x000, 0x001, in that order; 0x002 untouched.
- Second start (different dst) while busy in COPY len 8 → ignored: exactly 8 writes to the first dst, one done pulse.
- rst_n low after 2 words of FILL len 10 → outputs go to reset values asynchronously; no done pulse; a new FILL len 1 after reset completes normally.
